// File: rtl/iir_axis_pkg.sv
// Shared constants for the biquad-side AXI-Stream blocks.
//   IIR_DATA_WIDTH  : default signed sample width (matches biquad inout width)
//   IIR_FIFO_DEPTH  : default output FIFO entry count
//   IIR_LEVEL_WIDTH : occupancy width for the default depth (0..DEPTH inclusive)
//   iir_level_width : occupancy width helper for any depth
package iir_axis_pkg;

  localparam int unsigned IIR_DATA_WIDTH  = 16;
  localparam int unsigned IIR_FIFO_DEPTH  = 16;
  localparam int unsigned IIR_LEVEL_WIDTH = $clog2(IIR_FIFO_DEPTH) + 1;

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int unsigned iir_level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/iir_fifo_mem.sv
// Storage array for iir_axis_out_fifo: DEPTH x DATA_WIDTH registers,
// synchronous write, asynchronous read.
//   clk       : write clock
//   wr_en     : write strobe
//   wr_addr   : write address
//   wr_data   : write data
//   rd_addr   : read address
//   rd_data_c : combinational read data at rd_addr
module iir_fifo_mem
  import iir_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = IIR_DATA_WIDTH,
  parameter int unsigned DEPTH      = IIR_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data_c
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents need no reset: validity is tracked by the FIFO occupancy.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/iir_axis_out_fifo.sv
// Output FIFO for the biquad AXI-Stream sample path, first-word-fall-through.
// Optional overflow detector: define IIR_FIFO_OVF_DETECT_EN to compile it in.
//   clk, rst_n     : clock, asynchronous active-low reset
//   s_axis_tdata   : signed sample from the biquad
//   s_axis_tvalid  : sample valid from the biquad
//   s_axis_tready  : space available (level != DEPTH)
//   m_axis_tdata   : oldest stored sample (0 when empty)
//   m_axis_tvalid  : FIFO non-empty
//   m_axis_tready  : downstream consumer ready
//   level          : occupancy, 0..DEPTH
//   ovf_flag       : sticky "sample offered while full" (0 when detector absent)
// DEPTH must be a power of two in 4..256 so pointers wrap naturally.
module iir_axis_out_fifo
  import iir_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = IIR_DATA_WIDTH,
  parameter int unsigned DEPTH      = IIR_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf_flag
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = iir_level_width(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tready_q, tready_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [DATA_WIDTH-1:0] mem_rd_data_c;
  logic                  push_c;
  logic                  pop_c;

  assign push_c = s_axis_tvalid && tready_q;
  assign pop_c  = tvalid_q && m_axis_tready;

  // The memory is read at the post-edge head address so the head sample can be
  // registered onto m_axis_tdata.
  iir_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en     (push_c),
    .wr_addr   (wr_ptr_q),
    .wr_data   (s_axis_tdata),
    .rd_addr   (rd_ptr_d),
    .rd_data_c (mem_rd_data_c)
  );

  // Next-state: pointers, occupancy, and the registered head/flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    tvalid_d = tvalid_q;
    tready_d = tready_q;
    tdata_d  = tdata_q;

    wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    level_d  = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
    tvalid_d = (level_d != LVL_W'(0));
    tready_d = (level_d != LVL_W'(DEPTH));

    // A sample written this edge into the slot that becomes head is not yet
    // visible in the array, so bypass it straight from the input.
    if (level_d == LVL_W'(0)) begin
      tdata_d = '0;
    end else if (push_c && (wr_ptr_q == rd_ptr_d)) begin
      tdata_d = s_axis_tdata;
    end else begin
      tdata_d = mem_rd_data_c;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      tvalid_q <= 1'b0;
      tready_q <= 1'b1;
      tdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      tvalid_q <= tvalid_d;
      tready_q <= tready_d;
      tdata_q  <= tdata_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign level         = level_q;

`ifdef IIR_FIFO_OVF_DETECT_EN
  logic ovf_q;

  // Sticky: any sample offered while full was lost upstream of this FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (s_axis_tvalid && (level_q == LVL_W'(DEPTH))) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_flag = ovf_q;
`else
  assign ovf_flag = 1'b0;
`endif

endmodule

// File: tb/tb_iir_axis_out_fifo.sv
// Directed self-checking bench for iir_axis_out_fifo (DATA_WIDTH=16, DEPTH=16).
module tb_iir_axis_out_fifo;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int          NRESP = 24;
`ifdef IIR_FIFO_OVF_DETECT_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [4:0]    level;
  logic          ovf_flag;

  int checks   = 0;
  int failures = 0;

  iir_axis_out_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .level         (level),
    .ovf_flag      (ovf_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference biquad, Q14 coefficients, y = (b.x - a1*y1 - a2*y2) >>> 14.
  logic [DW-1:0] resp [NRESP];
  task automatic gen_resp();
    int x0, x1, x2, y1, y2, acc, y;
    x1 = 0; x2 = 0; y1 = 0; y2 = 0;
    for (int n = 0; n < NRESP; n++) begin
      x0  = (n == 0) ? 8192 : 0;
      acc = 2962 * x0 + 5615 * x1 + 2962 * x2 + 9362 * y1 - 5203 * y2;
      y   = acc >>> 14;
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      resp[n] = DW'(y);
      x2 = x1; x1 = x0; y2 = y1; y1 = y;
    end
  endtask

  initial begin
    int prod_idx;
    int cons_idx;
    int cyc;
    logic do_push;
    logic do_pop;

    rst_n = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    gen_resp();

    // Reset state.
    #12;
    chk("rst_level",  32'(level), 32'd0);
    chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_sready", 32'(s_axis_tready), 32'd1);
    chk("rst_mdata",  32'(m_axis_tdata), 32'd0);
    chk("rst_ovf",    32'(ovf_flag), 32'd0);
    tick();
    rst_n = 1'b1;

    // Single push of 32767 into empty FIFO.
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 16'd32767;
    tick();
    s_axis_tvalid = 1'b0;
    chk("one_mvalid", 32'(m_axis_tvalid), 32'd1);
    chk("one_mdata",  32'(m_axis_tdata), 32'd32767);
    chk("one_level",  32'(level), 32'd1);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    chk("one_drain_level",  32'(level), 32'd0);
    chk("one_drain_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("one_drain_mdata",  32'(m_axis_tdata), 32'd0);

    // Fill with 1..16 while consumer stalled.
    for (int i = 1; i <= 16; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = DW'(i);
      tick();
    end
    chk("full_level",  32'(level), 32'd16);
    chk("full_sready", 32'(s_axis_tready), 32'd0);
    chk("full_head",   32'(m_axis_tdata), 32'd1);
    chk("full_ovf_pre", 32'(ovf_flag), 32'd0);

    // 17th sample -5 offered while full: dropped.
    s_axis_tdata = 16'hFFFB;
    tick();
    s_axis_tvalid = 1'b0;
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_flag",  32'(ovf_flag), 32'(OVF_EXP));
    chk("ovf_head",  32'(m_axis_tdata), 32'd1);

    // Drain: 1..16 in order, -5 never appears.
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", 32'(m_axis_tdata), 32'(i));
      tick();
    end
    m_axis_tready = 1'b0;
    chk("drain_level",  32'(level), 32'd0);
    chk("drain_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("drain_sready", 32'(s_axis_tready), 32'd1);

    // Level 8, then 20 cycles of simultaneous push/pop across pointer wrap.
    for (int i = 0; i < 8; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = DW'(100 + i);
      tick();
    end
    chk("steady_fill_level", 32'(level), 32'd8);
    m_axis_tready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      s_axis_tdata = DW'(108 + k);
      chk("steady_data", 32'(m_axis_tdata), 32'(100 + k));
      tick();
      chk("steady_level", 32'(level), 32'd8);
    end
    s_axis_tvalid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("steady_tail", 32'(m_axis_tdata), 32'(120 + k));
      tick();
    end
    m_axis_tready = 1'b0;
    chk("steady_empty", 32'(level), 32'd0);

    // Biquad impulse response via pulse-style producer, consumer held 5570 ns.
    prod_idx = 0;
    cons_idx = 0;
    cyc = 0;
    while ((cons_idx < NRESP) && (cyc < 2000)) begin
      s_axis_tvalid = (prod_idx < NRESP) && cyc[0];
      s_axis_tdata  = (prod_idx < NRESP) ? resp[prod_idx] : '0;
      m_axis_tready = (cyc * 10 >= 5570);
      do_push = s_axis_tvalid && s_axis_tready;
      do_pop  = m_axis_tvalid && m_axis_tready;
      if (do_pop) begin
        chk("biquad_seq", 32'(m_axis_tdata), 32'(resp[cons_idx]));
        cons_idx++;
      end
      tick();
      if (do_push) prod_idx++;
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    chk("biquad_count", 32'(cons_idx), 32'(NRESP));
    chk("biquad_empty", 32'(level), 32'd0);

    // Reset mid-stream with level 5.
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = DW'(200 + i);
      tick();
    end
    s_axis_tvalid = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_level",  32'(level), 32'd0);
    chk("midrst_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midrst_ovf",    32'(ovf_flag), 32'd0);
    chk("midrst_mdata",  32'(m_axis_tdata), 32'd0);
    tick();
    rst_n = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 16'd77;
    tick();
    s_axis_tvalid = 1'b0;
    chk("post_rst_level", 32'(level), 32'd1);
    chk("post_rst_mdata", 32'(m_axis_tdata), 32'd77);
    m_axis_tready = 1'b1;
    tick();
    chk("post_rst_drain", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iir_axis_out_fifo.md
IIR_AXIS_OUT_FIFO -- requirements
Module: iir_axis_out_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed sample width matching biquad inout_width.
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, 4..256.
REQ-003 SHALL have port clk  input  1  single clock for all state.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_axis_tdata  input  DATA_WIDTH  signed sample from the biquad m_axis_tdata.
REQ-006 SHALL have port s_axis_tvalid  input  1  sample-valid from the biquad.
REQ-007 SHALL have port s_axis_tready  output  1  space available; drives the biquad m_axis_tready.
REQ-008 SHALL have port m_axis_tdata  output  DATA_WIDTH  oldest stored sample.
REQ-009 SHALL have port m_axis_tvalid  output  1  FIFO non-empty.
REQ-010 SHALL have port m_axis_tready  input  1  downstream consumer ready.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 SHALL have port ovf_flag  output  1  sticky overflow indicator (see REQ-027).

Function
REQ-013 SHALL accept (push) on a rising clk edge where s_axis_tvalid && s_axis_tready.
REQ-014 SHALL deliver (pop) on a rising clk edge where m_axis_tvalid && m_axis_tready.
REQ-015 SHALL drive s_axis_tready = (level != DEPTH), no combinational path from m_axis_tready.
REQ-016 SHALL drive m_axis_tvalid = (level != 0), first-word-fall-through: a sample pushed into an empty FIFO appears on m_axis_tdata/m_axis_tvalid in the cycle after the accepting edge.
REQ-017 SHALL hold m_axis_tdata stable while m_axis_tvalid && !m_axis_tready.
REQ-018 SHALL preserve order; data bit-exact, no arithmetic or width change.
REQ-019 SHALL, on simultaneous push and pop, keep level unchanged and advance both pointers; legal when empty-to-one is not pending (empty: pop impossible, push only).
REQ-020 SHALL, with s_axis_tvalid high while full, discard the sample, leave memory and level unchanged.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; full/empty derived from level, never pointer equality alone.
REQ-022 SHALL treat a one-cycle s_axis_tvalid pulse (biquad output style) as exactly one push.

Reset
REQ-023 SHALL, while rst_n low, asynchronously clear pointers, level=0, m_axis_tvalid=0, s_axis_tready=1, m_axis_tdata=0, ovf_flag=0.
REQ-024 SHALL, on reset asserted mid-stream, discard all stored samples; first push after release is the first sample delivered.
REQ-025 SHALL accept a push on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL use macro IIR_FIFO_OVF_DETECT_EN to compile the overflow detector in or out.
REQ-027 SHALL, with macro defined, set ovf_flag on any edge with s_axis_tvalid && level==DEPTH, held until reset.
REQ-028 SHALL, without macro, tie ovf_flag to 0 and instantiate no detector logic.

Structure
REQ-029 SHALL place DATA_WIDTH default and a level-width helper constant in shared package iir_axis_pkg, imported by biquad-side blocks.
REQ-030 SHALL implement storage in one sub-module iir_fifo_mem: DEPTH x DATA_WIDTH register array, synchronous write, asynchronous read.

Verification
REQ-031 SHALL cover: reset, single push of 32767 into empty FIFO -> m_axis_tvalid=1 and m_axis_tdata=32767 one cycle later, level=1.
REQ-032 SHALL cover: m_axis_tready=0, 16 pushes of values 1..16 -> level=16, s_axis_tready=0; then m_axis_tready=1 -> outputs 1..16 in order, level returns 0.
REQ-033 SHALL cover: full FIFO plus 17th push value -5 -> sample dropped, -5 never delivered, ovf_flag=1 (macro defined) or 0 (undefined).
REQ-034 SHALL cover: level=8, push and pop same edge for 20 cycles -> level stays 8, order preserved across pointer wrap.
REQ-035 SHALL cover: biquad instance (b0=2962,b1=5615,b2=2962,a1=-9362,a2=5203,scale 14) feeding FIFO, consumer tready low 5570 ns -> FIFO output sequence equals biquad impulse response with no gaps or duplicates.
REQ-036 SHALL cover: rst_n pulsed low with level=5 -> level=0, m_axis_tvalid=0 immediately, ovf_flag=0.
